// File: rtl/serial_tx_piso.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over valid/ready
// and drives it LSB-first on Shift_out, one bit per CLK, with Hold to stall mid-word.
module serial_tx_piso #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             Load_valid,
  output logic             Load_ready,
  input  logic             Hold,
  output logic             Shift_out,
  output logic             Tx_active,
  output logic             Done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;
  logic             shout_q;
  logic             tx_q;

  logic             last_s;
  logic             xfer_s;

  // Last-bit decode drives both Done and the zero-gap reload window.
  always_comb begin
    last_s     = (state_q == SHIFT) && (cnt_q == LAST) && !Hold;
    Load_ready = !Reset && ((state_q == IDLE) || last_s);
    Done       = !Reset && last_s;
    xfer_s     = Load_valid && Load_ready;
  end

  // Transmit FSM: load, shift, hold and return-to-idle.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      shout_q <= 1'b0;
      tx_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer_s) begin
            state_q <= SHIFT;
            shout_q <= Din[0];
            sreg_q  <= Din >> 1;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
            shout_q <= 1'b0;
            tx_q    <= 1'b0;
          end
        end
        SHIFT: begin
          if (Hold) begin
            state_q <= SHIFT;
          end else if (cnt_q != LAST) begin
            shout_q <= sreg_q[0];
            sreg_q  <= {1'b0, sreg_q[WIDTH-1:1]};
            cnt_q   <= cnt_q + CW'(1);
          end else if (Load_valid) begin
            // Reload on the last bit so the next word follows with no gap.
            state_q <= SHIFT;
            shout_q <= Din[0];
            sreg_q  <= Din >> 1;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
            shout_q <= 1'b0;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          sreg_q  <= '0;
          cnt_q   <= '0;
          shout_q <= 1'b0;
          tx_q    <= 1'b0;
        end
      endcase
    end
  end

  assign Shift_out = shout_q;
  assign Tx_active = tx_q;

endmodule

// File: doc/serial_tx_piso.md
# serial_tx_piso

Parallel-in, serial-out transmitter: the sending end of the team's serial shift-register link. Accepts a WIDTH-bit word through a valid/ready handshake and drives it LSB-first on a single serial line, one bit per CLK. Bit ordering matches the receiving shift register: after WIDTH shifts its Bit_0..Bit_(WIDTH-1) holds the transmitted word. Supports back-to-back words with no idle gap and a Hold input to stall mid-word.

## Interface
- WIDTH, 4, word length in bits; legal range 2..32.
- CLK  input  1  clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Din  input  WIDTH  parallel word; sampled only on handshake.
- Load_valid  input  1  Din is valid.
- Load_ready  output  1  block can accept a word this cycle (combinational from state/counter/Hold).
- Hold  input  1  stall; freezes shifting while high.
- Shift_out  output  1  serial data, registered.
- Tx_active  output  1  high while Shift_out carries a data bit, registered.
- Done  output  1  one-cycle pulse in the cycle the last bit of a word is driven.

## Operation
- Reset and clock: reset Reset, synchronous, active-high; clock CLK.
- Reset values: state IDLE, shift register 0, bit counter 0, Shift_out 0, Tx_active 0, Done 0. Load_ready 1 the cycle after reset deasserts.
- States: IDLE, SHIFT.
- Handshake: transfer occurs on a rising edge where Load_valid && Load_ready. Din is captured only then; Din changes at other times are ignored.
- Load_ready = (IDLE) || (SHIFT && count == WIDTH-1 && !Hold). Low at all other times, and low while Reset is high.
- IDLE: Shift_out 0, Tx_active 0. On transfer: Shift_out <= Din[0], shift register <= Din >> 1, count <= 0, Tx_active <= 1, go SHIFT.
- SHIFT, Hold=0, count < WIDTH-1: Shift_out <= sreg[0], sreg shifts right (zero fill), count++.
- SHIFT, Hold=0, count == WIDTH-1 (last bit on the line): with transfer, load new word exactly as from IDLE and stay SHIFT; without transfer, Shift_out <= 0, Tx_active <= 0, go IDLE.
- SHIFT, Hold=1: sreg, count, Shift_out, Tx_active all frozen; no transfer possible.
- Hold in IDLE has no effect; a word may be loaded with Hold high, and Hold then freezes it in the D[0] position.
- Done = SHIFT && count == WIDTH-1 && !Hold (registered or equivalently decoded; must be high exactly one non-held cycle per word).
- Counter width: clog2(WIDTH); never exceeds WIDTH-1.
- Reset mid-word: word discarded, no Done; next cycle all outputs at reset values.
- Reset and Load_valid together: reset wins, no word captured.

## Timing
- Transfer at edge k: Shift_out = Din[i] during cycle k+1+i, i = 0..WIDTH-1 (absent Hold). Tx_active high cycles k+1..k+WIDTH.
- Latency handshake -> first bit: 1 cycle. Word duration: WIDTH cycles plus held cycles.
- Done and Load_ready high in cycle k+WIDTH; transfer there gives next word's bit 0 in cycle k+WIDTH+1 (zero gap, Tx_active stays high).
- Each cycle of Hold during SHIFT extends the current bit by one cycle.
- Sustained throughput: one word per WIDTH cycles.

## Test plan
- Reset, then WIDTH=4, Din=4'b1011 with Load_valid one cycle -> Shift_out 1,1,0,1 on cycles k+1..k+4, Tx_active high 4 cycles, Done high only in k+4, then IDLE with Shift_out 0.
- Back-to-back: 4'hA then 4'h5, Load_valid held high -> serial 0,1,0,1,1,0,1,0 contiguous, Tx_active high 8 cycles, two Done pulses, Load_ready low during bits 0..2 of each word.
- Hold for 3 cycles during bit 1 of 4'b0110 -> Shift_out stays 1 for 4 cycles, total word 7 cycles, Done once, Load_ready low throughout hold.
- Reset asserted at bit 2 of 4'hF -> next cycle Shift_out 0, Tx_active 0, no Done, Load_ready 1 after reset release; subsequent 4'h3 sends 1,1,0,0.
- Loopback to 4-bit receiving shift register, 100 random words with random Load_valid and Hold gaps (receiver clock-enabled by Tx_active && !Hold) -> receiver Bit_0..Bit_3 equals each sent word on every Done+1 cycle.
- WIDTH=8, Din=8'h81 -> bits 1,0,0,0,0,0,0,1, Done in 8th cycle, counter wraps to 0 without overshoot.
